dict_ram_arbiter: RTL and testbench

DICT_RAM_ARBITER -- requirements
Module: dict_ram_arbiter

---
 rtl/dict_ram_arbiter.sv | 117 +++++++++++
 tb/tb_dict_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_ram_arbiter.sv
// Two-requester arbiter that serialises reads/writes onto a single-port async RAM bus.
// Define DICT_ARB_FIXED_PRIO_EN for fixed req0 priority; the default is round-robin.
module dict_ram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR      = 2'd1;
    localparam logic [1:0] RD_ADDR = 2'd2;
    localparam logic [1:0] RD_DATA = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  id_q;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  gnt0, gnt1, idle, hs;

`ifdef DICT_ARB_FIXED_PRIO_EN
    assign gnt1 = req1_valid & ~req0_valid;
`else
    // last_q = 1 means req1 won the previous handshake, so req0 wins the next tie.
    logic last_q;
    assign gnt1 = req1_valid & (~req0_valid | ~last_q);
`endif
    assign gnt0 = req0_valid & ~gnt1;

    assign idle       = (state_q == IDLE);
    assign req0_ready = idle & gnt0;
    assign req1_ready = idle & gnt1;
    assign hs         = req0_ready | req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = (req1_ready ? req1_we : req0_we) ? WR : RD_ADDR;
            WR:      state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_q == RD_DATA);
            if (hs) begin
                we_q    <= req1_ready ? req1_we    : req0_we;
                addr_q  <= req1_ready ? req1_addr  : req0_addr;
                wdata_q <= req1_ready ? req1_wdata : req0_wdata;
                id_q    <= req1_ready;
            end
            if (state_q == RD_DATA) begin
                rsp_rdata_q <= ram_data;
                rsp_id_q    <= id_q;
            end
        end
    end

`ifndef DICT_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  last_q <= 1'b1;
        else if (hs) last_q <= req1_ready;
    end
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = ~idle;
    assign ram_cs    = ~idle;
    assign ram_we    = (state_q == WR);
    assign ram_oe    = (state_q == RD_ADDR) | (state_q == RD_DATA);
    assign ram_addr  = addr_q;
    // Only the write state may drive the shared bus; the RAM owns it otherwise.
    assign ram_data  = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_dict_ram_arbiter.sv
// Randomized bench for dict_ram_arbiter with an operation-level model and an external RAM model.
module tb_dict_ram_arbiter;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [3:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, ram_cs, ram_we, ram_oe, busy;
    logic [31:0] rsp_rdata;
    logic [3:0]  ram_addr;
    wire  [31:0] ram_data;

    dict_ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_data(ram_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // External asynchronous-read RAM
    logic [31:0] ram_mem [16];
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_addr] : 32'bz;
    always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operation-level model: each accepted op occupies the bus for a fixed window.
    logic [31:0] m_mem [16];
    logic        m_last;
    int          free_at, cur_t, rsp_t;
    logic        have_op, cur_we, rsp_pend, rsp_i, exp_rid;
    logic [3:0]  cur_addr;
    logic [31:0] cur_wdata, rsp_d, exp_rdata;
    logic        hs0_n = 1'b0, hs1_n = 1'b0;
    int          glog[$];
    int          last_rd_hs, last_rsp_cyc;
    logic        last_rsp_id;
    logic [31:0] last_rsp_data;

    always @(negedge clk) begin
        logic idle, ew0, ew1, in_op, e_rv, gid;
        hs0_n = 1'b0;
        hs1_n = 1'b0;
        if (!rst_n) begin
            m_last = 1'b1; free_at = 0; have_op = 1'b0; rsp_pend = 1'b0;
            exp_rdata = '0; exp_rid = 1'b0;
        end else begin
            idle = (cyc >= free_at);
            if (req0_valid && req1_valid) begin
`ifdef DICT_ARB_FIXED_PRIO_EN
                ew1 = 1'b0;
`else
                ew1 = (m_last == 1'b0);
`endif
            end else ew1 = req1_valid;
            ew0 = req0_valid && !ew1;
            chk("ready0", {31'b0, req0_ready}, {31'b0, idle && ew0});
            chk("ready1", {31'b0, req1_ready}, {31'b0, idle && ew1});
            chk("busy", {31'b0, busy}, {31'b0, !idle});
            in_op = have_op && (cyc > cur_t) && (cyc < free_at);
            chk("ram_cs", {31'b0, ram_cs}, {31'b0, in_op});
            chk("ram_we", {31'b0, ram_we}, {31'b0, in_op && cur_we});
            chk("ram_oe", {31'b0, ram_oe}, {31'b0, in_op && !cur_we});
            if (in_op) chk("ram_addr", {28'b0, ram_addr}, {28'b0, cur_addr});
            if (in_op && cur_we) chk("ram_data_wr", ram_data, cur_wdata);
            e_rv = rsp_pend && (cyc == rsp_t);
            if (e_rv) begin
                exp_rdata = rsp_d; exp_rid = rsp_i; rsp_pend = 1'b0;
            end
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_id", {31'b0, rsp_id}, {31'b0, exp_rid});
            if (rsp_valid) begin
                last_rsp_cyc = cyc; last_rsp_id = rsp_id; last_rsp_data = rsp_rdata;
            end
            if (idle && (ew0 || ew1)) begin
                gid = ew1;
                glog.push_back(int'(gid));
                have_op   = 1'b1;
                cur_t     = cyc;
                cur_we    = gid ? req1_we : req0_we;
                cur_addr  = gid ? req1_addr : req0_addr;
                cur_wdata = gid ? req1_wdata : req0_wdata;
                m_last    = gid;
                if (cur_we) begin
                    free_at = cyc + 2;
                    m_mem[cur_addr] = cur_wdata;
                end else begin
                    free_at = cyc + 3;
                    rsp_pend = 1'b1; rsp_t = cyc + 3;
                    rsp_d = m_mem[cur_addr]; rsp_i = gid;
                    last_rd_hs = cyc;
                end
            end
            hs0_n = req0_valid && req0_ready;
            hs1_n = req1_valid && req1_ready;
        end
    end

    // Requesters: present the queue head, hold it until the handshake.
    op_t q0[$], q1[$];
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            req0_valid = 1'b0; q0.delete();
        end else begin
            if (hs0_n) begin void'(q0.pop_front()); req0_valid = 1'b0; end
            if (!req0_valid && q0.size() > 0) begin
                req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].data;
                req0_valid = 1'b1;
            end
        end
    end
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            req1_valid = 1'b0; q1.delete();
        end else begin
            if (hs1_n) begin void'(q1.pop_front()); req1_valid = 1'b0; end
            if (!req1_valid && q1.size() > 0) begin
                req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].data;
                req1_valid = 1'b1;
            end
        end
    end

    task automatic push(input int id, input logic we, input logic [3:0] a, input logic [31:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        if (id == 0) q0.push_back(o); else q1.push_back(o);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
                     cyc >= free_at && !rsp_pend) && n < budget);
        chk("drain_timeout", {31'b0, n >= budget}, 32'd0);
    endtask

    task automatic chk_read(input string name, input logic id, input logic [31:0] d);
        chk({name, "_data"}, last_rsp_data, d);
        chk({name, "_id"}, {31'b0, last_rsp_id}, {31'b0, id});
        chk({name, "_lat"}, last_rsp_cyc - last_rd_hs, 32'd3);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 32'h1111_0000 + i;
            m_mem[i]   = 32'h1111_0000 + i;
        end
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobes", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        chk("rst_rsp", {30'b0, rsp_valid, rsp_id}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Contention right after reset
        glog.delete();
        @(negedge clk);
        push(0, 1'b0, 4'd3, 32'd0); push(0, 1'b0, 4'd3, 32'd0);
        push(1, 1'b0, 4'd5, 32'd0); push(1, 1'b0, 4'd5, 32'd0);
        wait_drain(100);
        chk("grant_count", glog.size(), 32'd4);
`ifdef DICT_ARB_FIXED_PRIO_EN
        chk("grant_seq", {28'b0, glog[0][0], glog[1][0], glog[2][0], glog[3][0]}, 32'b0011);
`else
        chk("grant_seq", {28'b0, glog[0][0], glog[1][0], glog[2][0], glog[3][0]}, 32'b0101);
`endif

        // Write then read back on req0
        push(0, 1'b1, 4'd2, 32'hABCDE123); push(0, 1'b0, 4'd2, 32'd0);
        wait_drain(100);
        chk_read("raw_a2", 1'b0, 32'hABCDE123);

        // Top address written by req1, read by req0
        push(1, 1'b1, 4'd15, 32'h0000_00FF);
        wait_drain(100);
        push(0, 1'b0, 4'd15, 32'd0);
        wait_drain(100);
        chk_read("raw_a15", 1'b0, 32'h0000_00FF);

        // Reset during RD_DATA
        push(0, 1'b0, 4'd2, 32'd0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!hs0_n && n < 50);
        chk("rst_hs_timeout", {31'b0, n >= 50}, 32'd0);
        @(posedge clk); @(posedge clk); #3;
        chk("pre_rst_oe", {31'b0, ram_oe}, 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_strobes", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_rsp_next", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        push(0, 1'b0, 4'd2, 32'd0);
        wait_drain(100);
        chk_read("post_rst_a2", 1'b0, 32'hABCDE123);

        // Random traffic from both requesters
        for (int i = 0; i < 40; i++) begin
            push(0, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
            push(1, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
        end
        wait_drain(1000);
        for (int i = 0; i < 30; i++)
            push(int'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
        wait_drain(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
